div_fp_param: RTL and testbench



---
 rtl/div_fp_pkg.sv | 27 ++
 rtl/div_fp_param_if.sv | 26 ++
 rtl/div_fp_step.sv | 22 ++
 rtl/div_fp_param.sv | 142 ++++++++++++++
 tb/tb_div_fp_param.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/div_fp_pkg.sv
// Shared types and sizing helpers for the fixed-point divider.
// The rounding build is selected with the DIV_FP_ROUND_EN macro (see div_fp_param.sv).
package div_fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEF_N  = 32;
    localparam int DEF_FP = 8;

    // Value every saturated/invalid result bit takes.
    localparam logic SAT_BIT = 1'b1;

    // Internal dividend width: integer bits plus fractional bits.
    function automatic int calc_w(input int n, input int fp);
        return n + fp;
    endfunction

    // Counter width large enough for W+1 iterations plus headroom.
    function automatic int calc_cnt_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/div_fp_param_if.sv
// Operand/result handshake bundle for the fixed-point divider.
interface div_fp_param_if #(
    parameter int N = 32
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] OUT;
    logic         ovrflow;
    logic         inv;
    logic         out_valid;
    logic         out_ready;

    // Producer/consumer side: supplies operands, accepts results.
    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, OUT, ovrflow, inv, out_valid
    );

    // Divider side.
    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, OUT, ovrflow, inv, out_valid
    );
endinterface

// File: rtl/div_fp_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module div_fp_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);
    // The shifted remainder needs N+1 bits before the compare; after a
    // successful subtract the result is below the divisor, so N bits hold it.
    logic [N:0] rem_shift;

    // Compare and conditionally subtract.
    always_comb begin
        rem_shift = {rem_in, bit_in};
        q_bit     = (rem_shift >= {1'b0, divisor});
        rem_out   = rem_shift[N-1:0] - (q_bit ? divisor : '0);
    end
endmodule

// File: rtl/div_fp_param.sv
// Iterative unsigned fixed-point divider: OUT = (A << FP) / B, one quotient
// bit per clock, with saturation on overflow and a fast divide-by-zero path.
// Define DIV_FP_ROUND_EN for round-half-up (one extra guard iteration).
module div_fp_param
    import div_fp_pkg::*;
#(
    parameter int N  = 32,
    parameter int FP = 8
) (
    input  logic          clk,
    input  logic          rst,
    div_fp_param_if.slave bus
);
    localparam int W  = calc_w(N, FP);
    localparam int CW = calc_cnt_w(W);
`ifdef DIV_FP_ROUND_EN
    localparam int ITER = W + 1;
`else
    localparam int ITER = W;
`endif
    localparam logic [CW-1:0] ITER_CNT = CW'(ITER);
    localparam logic [N-1:0]  SAT      = {N{SAT_BIT}};

    state_t          state_reg, state_next;
    logic [W-1:0]    dividend_reg;
    logic [N-1:0]    divisor_reg;
    logic [N-1:0]    rem_reg;
    logic [ITER-2:0] quot_reg;
    logic [CW-1:0]   count_reg;
    logic [N-1:0]    out_reg;
    logic            ovf_reg;
    logic            inv_reg;

    logic [N-1:0]    rem_step;
    logic            q_bit;
    logic [ITER-1:0] quot_next;
    logic [N-1:0]    res_out;
    logic            res_ovf;
    logic            b_zero;

    div_fp_step #(.N(N)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (dividend_reg[W-1]),
        .divisor (divisor_reg),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    assign quot_next = {quot_reg, q_bit};
    assign b_zero    = (bus.B == '0);

`ifdef DIV_FP_ROUND_EN
    logic [W:0] q_round;

    // Round half-up with the guard bit; the carry may push into bit N.
    always_comb begin
        q_round = {1'b0, quot_next[ITER-1:1]} + (W+1)'(quot_next[0]);
        res_ovf = |q_round[W:N];
        res_out = res_ovf ? SAT : q_round[N-1:0];
    end
`else
    // Truncated quotient; anything above bit N-1 means it does not fit.
    always_comb begin
        res_ovf = |quot_next[W-1:N];
        res_out = res_ovf ? SAT : quot_next[N-1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = b_zero ? DONE : BUSY;
            end
            BUSY: begin
                if (count_reg == CW'(1)) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            count_reg    <= '0;
            out_reg      <= '0;
            ovf_reg      <= 1'b0;
            inv_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        dividend_reg <= W'(bus.A) << FP;
                        divisor_reg  <= bus.B;
                        rem_reg      <= '0;
                        quot_reg     <= '0;
                        count_reg    <= ITER_CNT;
                        if (b_zero) begin
                            out_reg <= SAT;
                            ovf_reg <= 1'b0;
                            inv_reg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dividend_reg <= dividend_reg << 1;
                    rem_reg      <= rem_step;
                    quot_reg     <= quot_next[ITER-2:0];
                    count_reg    <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        out_reg <= res_out;
                        ovf_reg <= res_ovf;
                        inv_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.OUT     = out_reg;
    assign bus.ovrflow = ovf_reg;
    assign bus.inv     = inv_reg;
endmodule

// File: tb/tb_div_fp_param.sv
// Self-checking bench for div_fp_param (N=32, FP=8), directed plus random.
module tb_div_fp_param;
`ifdef DIV_FP_ROUND_EN
    localparam int LAT = 41;
    localparam logic [31:0] EXP_2_3 = 32'h0000_00AB;
`else
    localparam int LAT = 40;
    localparam logic [31:0] EXP_2_3 = 32'h0000_00AA;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div_fp_param_if #(.N(32)) bus ();

    div_fp_param #(.N(32), .FP(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on (A * 2^FP) / B.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] o, output logic ov, output logic iv);
        longint unsigned x, q;
        if (b == 0) begin
            o = 32'hFFFF_FFFF; ov = 1'b0; iv = 1'b1;
        end else begin
            x = longint'(a) * 256;
`ifdef DIV_FP_ROUND_EN
            q = ((x * 2) / longint'(b) + 1) / 2;
`else
            q = x / longint'(b);
`endif
            iv = 1'b0;
            ov = (q >= 64'h1_0000_0000);
            o  = ov ? 32'hFFFF_FFFF : q[31:0];
        end
    endfunction

    task automatic wait_ready;
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 200) begin tick; k++; end
        chk("in_ready_wait", bus.in_ready, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin tick; lat++; end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic eov, input logic einv,
                         input int hold);
        int lat;
        wait_ready();
        bus.A = a; bus.B = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick;                                  // accepting edge
        bus.in_valid = 1'b0;
        bus.A = $urandom; bus.B = $urandom;    // operands must already be captured
        wait_valid(lat);
        chk("latency", 64'(lat), 64'((b == 0) ? 0 : LAT));
        chk("out", bus.OUT, eo);
        chk("ovrflow", bus.ovrflow, eov);
        chk("inv", bus.inv, einv);
        chk("in_ready_done", bus.in_ready, 0);
        repeat (hold) begin
            tick;
            chk("out_hold", bus.OUT, eo);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("valid_drop", bus.out_valid, 0);
        chk("ready_back", bus.in_ready, 1);
        $display("op A=0x%08h B=0x%08h OUT=0x%08h ovf=%0b inv=%0b lat=%0d",
                 a, b, eo, eov, einv, lat);
    endtask

    initial begin
        logic [31:0] ra, rb, eo;
        logic        eov, einv;
        int          lat;

        rst = 1'b1;
        bus.A = '0; bus.B = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (3) tick;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.OUT, 0);
        chk("rst_ovf", bus.ovrflow, 0);
        chk("rst_inv", bus.inv, 0);
        rst = 1'b0;
        tick;

        // Directed cases
        do_op(32'd3, 32'd2, 32'h0000_0180, 1'b0, 1'b0, 0);
        do_op(32'd2, 32'd3, EXP_2_3, 1'b0, 1'b0, 2);
        do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        do_op(32'h00FF_FFFF, 32'd1, 32'hFFFF_FF00, 1'b0, 1'b0, 0);
        do_op(32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);

        // Back-pressure: new operands offered while the result is held
        wait_ready();
        bus.A = 32'd100; bus.B = 32'd5; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'(LAT));
        bus.A = 32'd9; bus.B = 32'd3; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_out_stable", bus.OUT, 32'h0000_1400);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick;                                  // handshake edge
        bus.out_ready = 1'b0;
        chk("bp_valid_drop", bus.out_valid, 0);
        chk("bp_ready_back", bus.in_ready, 1);
        tick;                                  // held in_valid is accepted now
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp2_latency", 64'(lat), 64'(LAT));
        chk("bp2_out", bus.OUT, 32'h0000_0300);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        $display("backpressure first=0x00001400 second=0x%08h", bus.OUT);

        // Reset in the middle of an iteration
        wait_ready();
        bus.A = 32'h0001_2345; bus.B = 32'h77; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (20) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out", bus.OUT, 0);
        chk("mid_rst_ovf", bus.ovrflow, 0);
        chk("mid_rst_inv", bus.inv, 0);
        repeat (45) tick;
        chk("mid_rst_no_result", bus.out_valid, 0);
        $display("reset mid-operation aborted");
        do_op(32'd7, 32'd7, 32'h0000_0100, 1'b0, 1'b0, 0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            model(ra, rb, eo, eov, einv);
            do_op(ra, rb, eo, eov, einv, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
